// File: rtl/dmem_ctrl.sv
// dmem_ctrl: serialises RV32I loads/stores into little-endian byte accesses on a byte-wide SRAM.
// Optional misaligned-access trap enabled by defining DMEM_CTRL_MISALIGN_TRAP_EN.

`ifndef MEMORY_MODE_WIDTH
`define MEMORY_MODE_WIDTH 2
`endif
`ifndef BYTE_MEMORY_MODE
`define BYTE_MEMORY_MODE 2'b00
`endif
`ifndef HALFWORD_MEMORY_MODE
`define HALFWORD_MEMORY_MODE 2'b01
`endif
`ifndef WORD_MEMORY_MODE
`define WORD_MEMORY_MODE 2'b10
`endif

module dmem_ctrl #(
    parameter int unsigned MEM_ADDR_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          D_MEM_read,
    input  logic                          D_MEM_write,
    input  logic [`MEMORY_MODE_WIDTH-1:0] D_MEM_mode,
    input  logic                          load_unsigned,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata,
    output logic                          stall,
    output logic                          done,
    output logic                          misaligned,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
    output logic [7:0]                    mem_wdata,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic [7:0]                    mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e                        r_state, w_next_state;
    logic [MEM_ADDR_WIDTH-1:0]     r_addr;
    logic [31:0]                   r_wdata;
    logic [31:0]                   r_buf;
    logic [`MEMORY_MODE_WIDTH-1:0] r_mode;
    logic                          r_write;
    logic                          r_uns;
    logic                          r_mis;
    logic [2:0]                    r_k;

    logic       w_req;
    logic       w_req_mis;
    logic       w_last;
    logic [2:0] w_nbytes;
    logic [1:0] w_cap_idx;
    logic       w_unused_addr;

    assign w_req         = D_MEM_read | D_MEM_write;
    assign w_unused_addr = ^addr[31:MEM_ADDR_WIDTH];

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
    always_comb begin
        w_req_mis = 1'b0;
        if (D_MEM_mode == `HALFWORD_MEMORY_MODE) begin
            w_req_mis = addr[0];
        end else if (D_MEM_mode == `WORD_MEMORY_MODE) begin
            w_req_mis = |addr[1:0];
        end
    end
`else
    assign w_req_mis = 1'b0;
`endif

    always_comb begin
        case (r_mode)
            `BYTE_MEMORY_MODE:     w_nbytes = 3'd1;
            `HALFWORD_MEMORY_MODE: w_nbytes = 3'd2;
            default:               w_nbytes = 3'd4;
        endcase
    end

    assign w_last    = (r_k == w_nbytes - 3'd1);
    // Read byte k lands one cycle after its issue, by which time r_k has moved on to k+1.
    assign w_cap_idx = r_k[1:0] - 2'd1;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_next_state = w_req_mis ? StDone : StAccess;
                end
            end
            StAccess: begin
                if (w_last) begin
                    w_next_state = r_write ? StDone : StWait;
                end
            end
            StWait:  w_next_state = StDone;
            default: w_next_state = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
            r_mode  <= '0;
            r_write <= 1'b0;
            r_uns   <= 1'b0;
            r_mis   <= 1'b0;
            r_k     <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_addr  <= addr[MEM_ADDR_WIDTH-1:0];
                        r_wdata <= wdata;
                        r_mode  <= D_MEM_mode;
                        r_write <= D_MEM_write;
                        r_uns   <= load_unsigned;
                        r_mis   <= w_req_mis;
                        r_k     <= '0;
                        r_buf   <= '0;
                    end
                end
                StAccess: begin
                    r_k <= r_k + 3'd1;
                    if (!r_write && r_k != 3'd0) begin
                        r_buf[{w_cap_idx, 3'b000} +: 8] <= mem_rdata;
                    end
                end
                StWait: r_buf[{w_cap_idx, 3'b000} +: 8] <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign stall = ((r_state == StIdle) && w_req) || (r_state == StAccess) || (r_state == StWait);
    assign done  = (r_state == StDone);

    // Strobes are masked by reset so a byte whose edge coincides with reset is never written.
    assign mem_we    = (r_state == StAccess) && r_write && !rst;
    assign mem_re    = (r_state == StAccess) && !r_write && !rst;
    assign mem_addr  = (r_state == StAccess) ? r_addr + MEM_ADDR_WIDTH'(r_k) : '0;
    assign mem_wdata = ((r_state == StAccess) && r_write) ? r_wdata[{r_k[1:0], 3'b000} +: 8] : 8'h00;

    always_comb begin
        rdata = 32'h0;
        if ((r_state == StDone) && !r_write && !r_mis) begin
            case (r_mode)
                `BYTE_MEMORY_MODE:
                    rdata = r_uns ? {24'h0, r_buf[7:0]} : {{24{r_buf[7]}}, r_buf[7:0]};
                `HALFWORD_MEMORY_MODE:
                    rdata = r_uns ? {16'h0, r_buf[15:0]} : {{16{r_buf[15]}}, r_buf[15:0]};
                default:
                    rdata = r_buf;
            endcase
        end
    end

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
    assign misaligned = (r_state == StDone) && r_mis;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the RV32I pipeline's MEM stage. It consumes the decoded `D_MEM_read`, `D_MEM_write` and `D_MEM_mode` controls, the effective address and the store data. It serialises each load or store into little-endian byte accesses on a byte-wide synchronous SRAM port. It stalls the pipeline until the access completes, then returns sign- or zero-extended load data to the WB mux.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 16, width of the byte address driven to the SRAM; uses `addr[MEM_ADDR_WIDTH-1:0]`.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- D_MEM_read  input  1  load request from the MEM-stage pipeline register.
- D_MEM_write  input  1  store request.
- D_MEM_mode  input  `MEMORY_MODE_WIDTH`  access width: `BYTE_MEMORY_MODE`, `HALFWORD_MEMORY_MODE` or `WORD_MEMORY_MODE`.
- load_unsigned  input  1  funct3[2] of the instruction; 1 selects LBU/LHU zero-extension.
- addr  input  32  effective byte address (ALU output).
- wdata  input  32  store data ($rs2); the low 1, 2 or 4 bytes are used.
- rdata  output  32  extended load result; valid while `done`=1.
- stall  output  1  freezes the PC and the IF/ID/EX/MEM registers.
- done  output  1  one-cycle pulse when the access completes.
- misaligned  output  1  one-cycle pulse together with `done`; present only with the macro below, otherwise tied 0.
- mem_addr  output  MEM_ADDR_WIDTH  SRAM byte address.
- mem_wdata  output  8  SRAM write byte.
- mem_we  output  1  SRAM write strobe.
- mem_re  output  1  SRAM read strobe.
- mem_rdata  input  8  SRAM read byte, valid exactly one cycle after `mem_re`.

## Operation
- State machine: IDLE, ACCESS, WAIT, DONE.
- Byte count N: 1 for byte mode, 2 for halfword, 4 for word.
- IDLE:
  - On a request (read or write), latch addr, wdata, mode, direction and unsigned flag, clear the byte counter k, and go to ACCESS.
  - If both read and write are high, write wins and the read is ignored.
- ACCESS, one cycle per byte:
  - Drive mem_addr = latched addr + k, truncated modulo 2^MEM_ADDR_WIDTH (wraps at the top).
  - Writes: drive mem_we=1 and mem_wdata = wdata[8k+7:8k].
  - Reads: drive mem_re=1.
  - Increment k. After byte N-1, go to WAIT (reads) or DONE (writes).
- WAIT (reads only): capture the final byte, then go to DONE. Each read byte k is captured into buffer[8k+7:8k] the cycle after its issue.
- DONE: `done`=1 for one cycle, then return to IDLE unconditionally. The still-present request is not re-serviced; the pipeline advances on this edge.
- Load extension:
  - Byte: bit 7 replicated, or zeros if load_unsigned.
  - Halfword: bit 15 replicated, or zeros if load_unsigned.
  - Word: unchanged.
  - load_unsigned is ignored for word mode and for stores.
- rdata is 0 except in DONE after a read.

## Timing
- Reset values: state IDLE, stall 0, done 0, misaligned 0, rdata 0, mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0, k 0.
- stall is combinational:
  - 1 in IDLE while a request is present.
  - 1 in ACCESS and WAIT.
  - 0 in DONE and in IDLE with no request.
- Stall cycles: stores 1+N, loads 2+N. The instruction then completes in the DONE cycle. Byte load = 3 stall cycles, word load = 6, word store = 5.
- mem_* outputs are decoded from state: high only in ACCESS cycles, never in IDLE, WAIT or DONE.
- Back-to-back requests: the new request is seen in the IDLE cycle after DONE. There is no overlap.
- Reset mid-access:
  - Go to IDLE on the next edge; strobes drop.
  - A partially written word stays in SRAM; no rollback.
  - done is not pulsed.
- Inputs must be stable from the first stalled cycle through DONE. The block relies only on its latched copy.

## Configuration
- DMEM_CTRL_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, goes IDLE→DONE with no SRAM strobe.
  - misaligned=1 together with done; rdata=0; stall is 1 for one cycle.
- Undefined: misaligned accesses are performed byte-serially like aligned ones, and misaligned is constant 0.

## Test plan
- Reset, then SW addr=0x10, wdata=0xA1B2C3D4 -> mem_we on 4 consecutive cycles, addresses 0x10..0x13, bytes D4,C3,B2,A1; stall high 5 cycles; done in cycle 6.
- LB addr=0x10 with SRAM[0x10]=0x80 -> rdata=0xFFFFFF80 with done. LBU at the same address -> 0x00000080.
- LH addr=0x12 with bytes 0x34,0xF2 -> rdata=0xFFFFF234. LHU -> 0x0000F234. Stall high 4 cycles.
- Word load at addr=0xFFFE with MEM_ADDR_WIDTH=16 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001. With the macro defined: no strobe, misaligned=1, done after 1 stall cycle.
- Assert rst during the third ACCESS cycle of SW -> state IDLE next cycle; mem_we, stall and done all 0; SRAM holds only the first two bytes (the third byte's write edge coincides with the reset edge).
- SB then LW back-to-back, request held high during DONE -> exactly one write and one read serviced; no duplicate strobe after either DONE.
